// File: rtl/ym2612_write_scheduler_if.sv
// Requester handshake and YM2612 pin bundle for the write scheduler.
// The slave view is the scheduler; the master view is the requester/board side.
interface ym2612_write_scheduler_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_part;
  logic [8*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_data;
  logic              nIC, nCS, nWR, nRD, A0, A1;
  logic [7:0]        D_OUT;
  logic              D_OE;
  logic [7:0]        D_IN;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  req_valid, req_part, req_addr, req_data, D_IN,
    output req_ready, nIC, nCS, nWR, nRD, A0, A1, D_OUT, D_OE, busy, timeout_err
  );

  modport master (
    output req_valid, req_part, req_addr, req_data, D_IN,
    input  req_ready, nIC, nCS, nWR, nRD, A0, A1, D_OUT, D_OE, busy, timeout_err
  );
endinterface

// File: rtl/ym2612_write_scheduler.sv
// Round-robin arbiter feeding a status-poll / address / data sequencer onto the YM2612 bus.
// Pin outputs are registered from the next-state decode so the chip never sees glitches.
module ym2612_write_scheduler #(
  parameter int NREQ         = 2,
  parameter int SETUP_CYC    = 1,
  parameter int PULSE_CYC    = 2,
  parameter int HOLD_CYC     = 1,
  parameter int IC_CYC       = 16,
  parameter int BUSY_TIMEOUT = 255
) (
  input logic CLK,
  input logic nRST,
  ym2612_write_scheduler_if.slave bus
);
  localparam int P    = SETUP_CYC + PULSE_CYC + HOLD_CYC + 1;
  localparam int CMAX = (IC_CYC > P) ? IC_CYC : P;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PLW  = $clog2(BUSY_TIMEOUT + 1);
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [CW-1:0]  C_LAST = CW'(P - 1);
  localparam logic [CW-1:0]  C_SMP  = CW'(SETUP_CYC + PULSE_CYC - 1);
  localparam logic [CW-1:0]  C_PS   = CW'(SETUP_CYC);
  localparam logic [CW-1:0]  C_PE   = CW'(SETUP_CYC + PULSE_CYC);
  localparam logic [CW-1:0]  C_ICL  = CW'(IC_CYC - 1);
  localparam logic [PLW-1:0] C_TO   = PLW'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_STAT, S_ADDR, S_DATA} state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [PLW-1:0]  r_poll, w_poll_nx;
  logic [IW-1:0]   r_rr, w_gnt_idx;
  logic            w_gnt_vld, w_xfer, w_terr_set, w_last;
  logic [NREQ-1:0] w_ready;
  logic            r_part, r_bsy_smp;
  logic [7:0]      r_addr, r_data;
  logic            r_nic, r_ncs, r_nwr, r_nrd, r_a0, r_a1, r_oe, r_terr;
  logic [7:0]      r_dout;
  logic            w_acc_nx, w_rec_nx, w_pul_nx, w_wr_nx;

  // First valid requester strictly after the last winner, with wrap.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_gnt_vld && bus.req_valid[(int'(r_rr) + k) % NREQ]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IW'((int'(r_rr) + k) % NREQ);
      end
    end
  end

  assign w_ready       = (r_state == S_IDLE && w_gnt_vld) ? (NREQ'(1) << w_gnt_idx) : '0;
  assign bus.req_ready = w_ready;
  assign w_xfer        = |(bus.req_valid & w_ready);
  assign w_last        = (r_cnt == C_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_poll_nx  = r_poll;
    w_terr_set = 1'b0;
    case (r_state)
      S_INIT: if (r_cnt == C_ICL) begin w_state_nx = S_IDLE; w_cnt_nx = '0; end
      S_IDLE: begin
        w_cnt_nx = '0;
        if (w_xfer) begin w_state_nx = S_STAT; w_poll_nx = '0; end
      end
      S_STAT: if (w_last) begin
        w_cnt_nx = '0;
        if (!r_bsy_smp)          w_state_nx = S_ADDR;
        else if (r_poll < C_TO)  w_poll_nx  = r_poll + 1'b1;
        else begin w_terr_set = 1'b1; w_state_nx = S_ADDR; end
      end
      S_ADDR: if (w_last) begin w_cnt_nx = '0; w_state_nx = S_DATA; end
      S_DATA: if (w_last) begin w_cnt_nx = '0; w_state_nx = S_IDLE; end
      default: begin w_state_nx = S_INIT; w_cnt_nx = '0; end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_poll  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_poll  <= w_poll_nx;
    end
  end

  // Phase decode of the cycle about to start.
  assign w_acc_nx = (w_state_nx == S_STAT) || (w_state_nx == S_ADDR) || (w_state_nx == S_DATA);
  assign w_wr_nx  = (w_state_nx == S_ADDR) || (w_state_nx == S_DATA);
  assign w_rec_nx = (w_cnt_nx == C_LAST);
  assign w_pul_nx = (w_cnt_nx >= C_PS) && (w_cnt_nx < C_PE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rr      <= IW'(NREQ - 1);
      r_part    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_bsy_smp <= 1'b0;
      r_nic     <= 1'b0;
      r_ncs     <= 1'b1;
      r_nwr     <= 1'b1;
      r_nrd     <= 1'b1;
      r_a0      <= 1'b0;
      r_a1      <= 1'b0;
      r_dout    <= '0;
      r_oe      <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_rr   <= w_gnt_idx;
        r_part <= bus.req_part[w_gnt_idx];
        r_addr <= bus.req_addr[{w_gnt_idx, 3'b000} +: 8];
        r_data <= bus.req_data[{w_gnt_idx, 3'b000} +: 8];
      end
      if (r_state == S_STAT && r_cnt == C_SMP) r_bsy_smp <= bus.D_IN[7];
      if (w_terr_set) r_terr <= 1'b1;
      r_nic <= (w_state_nx != S_INIT);
      r_ncs <= !(w_acc_nx && !w_rec_nx);
      r_nrd <= !((w_state_nx == S_STAT) && w_pul_nx);
      r_nwr <= !(w_wr_nx && w_pul_nx);
      r_oe  <= w_wr_nx && !w_rec_nx;
      // Bus address/data only move while nCS is low.
      if (w_acc_nx && !w_rec_nx) begin
        r_a1 <= w_wr_nx ? r_part : 1'b0;
        r_a0 <= (w_state_nx == S_DATA);
        if (w_state_nx == S_ADDR) r_dout <= r_addr;
        if (w_state_nx == S_DATA) r_dout <= r_data;
      end
    end
  end

  assign bus.nIC         = r_nic;
  assign bus.nCS         = r_ncs;
  assign bus.nWR         = r_nwr;
  assign bus.nRD         = r_nrd;
  assign bus.A0          = r_a0;
  assign bus.A1          = r_a1;
  assign bus.D_OUT       = r_dout;
  assign bus.D_OE        = r_oe;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_terr;
endmodule

// File: tb/tb_ym2612_write_scheduler.sv
// Randomized scoreboard bench: stimulus pushes the expected bus accesses, a pin monitor pops them.
module tb_ym2612_write_scheduler;
  localparam int NREQ = 2, S = 1, PU = 2, H = 1, IC = 16, TO = 3;
  localparam int P = S + PU + H + 1;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  ym2612_write_scheduler_if #(.NREQ(NREQ)) bus();

  ym2612_write_scheduler #(
    .NREQ(NREQ), .SETUP_CYC(S), .PULSE_CYC(PU), .HOLD_CYC(H),
    .IC_CYC(IC), .BUSY_TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .nRST(rst_n), .bus(bus)
  );

  typedef struct packed {logic wr; logic a1; logic a0; logic [7:0] d;} acc_t;
  acc_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int rd_cnt = 0, rd_base = 0, bsy_n = 0;
  logic       pp[NREQ];
  logic [7:0] pa[NREQ], pd[NREQ];
  int  m_rr = NREQ - 1;
  bit  m_to = 1'b0;

  // Chip model: the first bsy_n status reads of a write see the busy flag.
  always @(posedge bus.nRD) rd_cnt = rd_cnt + 1;
  assign bus.D_IN = {((rd_cnt - rd_base) < bsy_n), 7'h15};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      int i = (m_rr + k) % NREQ;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic int min_to(input int bn);
    return (bn < TO) ? bn : TO;
  endfunction

  // Monitor: every strobe fall is one bus access compared against the scoreboard.
  logic mon_s, prev_s = 1'b0;
  int   pw = 0;
  acc_t e;
  always @(negedge CLK) begin
    if (!rst_n) begin
      prev_s = 1'b0;
      pw = 0;
    end else begin
      mon_s = !bus.nWR || !bus.nRD;
      if (mon_s && !prev_s) begin
        chk("strobe_excl", 32'(bus.nWR | bus.nRD), 1);
        chk("ncs_at_strobe", 32'(bus.nCS), 0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_access: got an access, expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("acc_kind", 32'(!bus.nWR), 32'(e.wr));
          chk("acc_a1", 32'(bus.A1), 32'(e.a1));
          chk("acc_a0", 32'(bus.A0), 32'(e.a0));
          chk("acc_oe", 32'(bus.D_OE), 32'(e.wr));
          if (e.wr) chk("acc_dout", 32'(bus.D_OUT), 32'(e.d));
        end
        pw = 1;
      end else if (mon_s) begin
        pw++;
      end else if (prev_s) begin
        chk("pulse_width", pw, PU);
      end
      prev_s = mon_s;
    end
  end

  task automatic drive_payload();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_part[i]       = pp[i];
      bus.req_addr[8*i +: 8] = pa[i];
      bus.req_data[8*i +: 8] = pd[i];
    end
  endtask

  task automatic rand_payload(input int i);
    pp[i] = 1'($urandom_range(0, 1));
    pa[i] = 8'($urandom);
    pd[i] = 8'($urandom);
  endtask

  // Raise the mask, wait for the transfer, load the scoreboard with what that write must do.
  task automatic wait_grant(input logic [NREQ-1:0] m, input int bn, output int g);
    int eg, cnt;
    acc_t a;
    eg = exp_grant(m);
    drive_payload();
    bus.req_valid = m;
    #1;
    cnt = 0;
    g = -1;
    while (!(|(bus.req_valid & bus.req_ready)) && cnt < 300) begin
      @(negedge CLK);
      cnt++;
    end
    if (cnt >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL grant_wait: got no ready in 300 cycles, expected a grant");
      return;
    end
    chk("ready_onehot", $countones(bus.req_ready), 1);
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
    chk("grant_idx", g, eg);
    rd_base = rd_cnt;
    bsy_n   = bn;
    for (int n = 0; n <= min_to(bn); n++) begin
      a = '{wr: 1'b0, a1: 1'b0, a0: 1'b0, d: 8'h00};
      exp_q.push_back(a);
    end
    a = '{wr: 1'b1, a1: pp[eg], a0: 1'b0, d: pa[eg]};
    exp_q.push_back(a);
    a = '{wr: 1'b1, a1: pp[eg], a0: 1'b1, d: pd[eg]};
    exp_q.push_back(a);
    m_rr = eg;
    if (bn > TO) m_to = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_txn(input logic [NREQ-1:0] m, input int bn, output int g);
    int cnt;
    wait_grant(m, bn, g);
    if (g < 0) return;
    cnt = 0;
    while (bus.busy && cnt < 2000) begin
      @(posedge CLK);
      #1;
      cnt++;
    end
    chk("txn_cycles", cnt, 3*P + P*min_to(bn));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_to));
    chk("exp_q_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, cnt;
    logic [NREQ-1:0] m;
    bus.req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin pp[i] = 1'b0; pa[i] = 8'h00; pd[i] = 8'h00; end
    drive_payload();

    // Reset values and INIT length.
    #23;
    chk("rst_pins", {23'd0, bus.nIC, bus.nCS, bus.nWR, bus.nRD, bus.A0, bus.A1, bus.D_OE, bus.busy, bus.timeout_err},
        32'b0_1110_0010);
    chk("rst_dout", 32'(bus.D_OUT), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    @(negedge CLK); #2 rst_n = 1'b1;
    cnt = 0;
    while (!bus.nIC && cnt < 100) begin @(posedge CLK); #1; cnt++; end
    chk("nic_low_cycles", cnt, IC);
    chk("busy_after_init", 32'(bus.busy), 0);
    chk("ncs_idle", 32'(bus.nCS), 1);

    // Directed writes: idle chip, then three busy status reads.
    pp[0] = 1'b0; pa[0] = 8'h28; pd[0] = 8'hF0;
    do_txn(2'b01, 0, g);
    bus.req_valid = '0;
    pp[1] = 1'b1; pa[1] = 8'hA4; pd[1] = 8'h22;
    do_txn(2'b10, 3, g);
    bus.req_valid = '0;

    // Both requesters held valid: strict alternation.
    rand_payload(0); rand_payload(1);
    for (int t = 0; t < 4; t++) begin
      do_txn(2'b11, 0, g);
      if (g >= 0) rand_payload(g);
    end
    bus.req_valid = '0;

    // Busy stuck high: timeout, write still completes, flag sticks through the next write.
    rand_payload(0); rand_payload(1);
    do_txn(2'b01, 1000, g);
    bus.req_valid = '0;
    do_txn(2'b10, 0, g);
    bus.req_valid = '0;

    // Reset during the DATA strobe.
    rand_payload(0);
    wait_grant(2'b01, 0, g);
    cnt = 0;
    while (!(bus.nWR == 1'b0 && bus.A0 == 1'b1) && cnt < 100) begin @(negedge CLK); cnt++; end
    if (cnt >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL data_strobe_wait: got no DATA strobe, expected one");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_nwr", 32'(bus.nWR), 1);
    chk("abort_ncs", 32'(bus.nCS), 1);
    chk("abort_oe", 32'(bus.D_OE), 0);
    chk("abort_terr", 32'(bus.timeout_err), 0);
    chk("abort_ready", 32'(bus.req_ready), 0);
    m_to = 1'b0;
    m_rr = NREQ - 1;
    exp_q.delete();
    @(posedge CLK); #1;
    chk("abort_nic", 32'(bus.nIC), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); #2 rst_n = 1'b1;
    cnt = 0;
    while (bus.req_ready == '0 && cnt < 100) begin @(negedge CLK); cnt++; end
    chk("reinit_wait", cnt, IC);
    do_txn(2'b01, 0, g);
    bus.req_valid = '0;

    // Random traffic; pending requesters keep valid until served.
    m = '0;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!m[i] && $urandom_range(0, 1) == 1) begin m[i] = 1'b1; rand_payload(i); end
      if (m == '0) begin m[0] = 1'b1; rand_payload(0); end
      do_txn(m, $urandom_range(0, 4), g);
      if (g >= 0) m[g] = 1'b0;
      bus.req_valid = m;
    end
    bus.req_valid = '0;
    repeat (5) @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ym2612_write_scheduler.md
# ym2612_write_scheduler

Arbitrates register-write requests from several sound-engine requesters and sequences each accepted write onto the YM2612 parallel bus. Every write runs as three accesses: a status read with busy-poll, an address write, then a data write. The block owns the chip's nIC, nCS, nWR, nRD, A0, A1 pins and the split data bus; the top level builds the tristate DATA pad from D_OUT/D_OE/D_IN.

## Interface
- NREQ, 2: number of requesters (2..8).
- SETUP_CYC, 1: cycles nCS low with address/data stable before the strobe.
- PULSE_CYC, 2: cycles nWR/nRD held low.
- HOLD_CYC, 1: cycles nCS low after the strobe rises.
- IC_CYC, 16: cycles nIC held low after reset.
- BUSY_TIMEOUT, 255: consecutive busy status reads allowed before the poll is abandoned.
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  one-hot grant. Transfer happens when valid[i]&ready[i].
- req_part  in  NREQ  per-requester part select: 0 = part I, 1 = part II.
- req_addr  in  8*NREQ  per-requester register address. Requester i uses bits [8i+7:8i].
- req_data  in  8*NREQ  per-requester register data, same packing.
- nIC, nCS, nWR, nRD, A0, A1  out  1 each  chip control pins.
- D_OUT  out  8  bus write data.
- D_OE  out  1  drive enable for D_OUT.
- D_IN  in  8  bus read data. Bit 7 is the chip busy flag.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on busy-poll timeout.

## Operation
- Reset values: nIC=0, nCS=nWR=nRD=1, A0=A1=0, D_OUT=0, D_OE=0, req_ready=0, busy=1, timeout_err=0, RR pointer=NREQ-1, state INIT.
- INIT: hold nIC=0 for IC_CYC cycles, then set nIC=1 and go to IDLE.
- IDLE: the grant goes to the first requester with valid set, searching upward (with wrap) from RR pointer+1. req_ready for that requester is driven combinationally from req_valid, and is only ever high in IDLE. On transfer, latch part/addr/data, set RR pointer to the granted index, and go to STAT.
- Requesters must hold valid and payload stable until ready is seen.
- Every access has the same phases: SETUP_CYC cycles with nCS=0 and strobes high, then PULSE_CYC cycles with the strobe low, then HOLD_CYC cycles with strobe high and nCS=0, then 1 RECOVER cycle with nCS=1.
- STAT access: A1=0, A0=0, strobe nRD, D_OE=0. D_IN[7] is sampled on the last PULSE cycle.
  - If bit 7 = 1 and the poll count is below BUSY_TIMEOUT: increment the count and repeat STAT.
  - If bit 7 = 1 and the count has reached BUSY_TIMEOUT: set timeout_err and proceed.
  - If bit 7 = 0: proceed to ADDR.
- ADDR access: A1=part, A0=0, D_OUT=addr, D_OE=1, strobe nWR.
- DATA access: A1=part, A0=1, D_OUT=data, D_OE=1, strobe nWR. Then return to IDLE.
- D_OE is high only during the SETUP, PULSE and HOLD phases of ADDR and DATA. It is 0 during RECOVER.
- A0, A1 and D_OUT keep their last values while nCS=1.
- The poll counter clears on every new grant.
- States: INIT, IDLE, STAT, ADDR, DATA. The phase counter is shared across states.

## Timing
- Let P = SETUP_CYC+PULSE_CYC+HOLD_CYC+1 (defaults: P=5).
- Transfer at edge k: the first STAT SETUP cycle is k+1. A non-busy write returns to IDLE at cycle k+1+3P (k+16 with defaults), and req_ready may assert in that cycle.
- Each busy status read adds P cycles.
- Back-to-back requests: at most one grant per 3P+1 cycles.
- Requests that are simultaneously valid are served strictly alternately (for NREQ=2), regardless of index.
- A request raised during a transaction waits; there is no queueing beyond the requester's own valid.
- nRST asserted mid-transaction: all outputs return to reset values immediately. The transaction is dropped with no partial nWR pulse completed, timeout_err clears, and INIT re-runs.
- nWR and nRD are never low together. A strobe is never low while nCS=1.

## Test plan
- Reset release with no requests: nIC low for exactly 16 cycles, then nCS stays 1 and busy falls to 0.
- Requester 0 writes part=0, addr=0x28, data=0xF0, with D_IN[7]=0: status read (A1=0, A0=0), then an nWR pulse with A0=0, D_OUT=0x28, then an nWR pulse with A1=0, A0=1, D_OUT=0xF0. Back in IDLE 15 cycles after the first STAT cycle.
- Requester 1 writes part=1, addr=0xA4, data=0x22, with D_IN[7] held 1 for 3 status reads: 4 status reads total, the two writes with A1=1, and the total adds 3P=15 cycles.
- Both requesters valid continuously for 4 transactions: grant order 0,1,0,1 (RR pointer starts at 1), with no ready overlap.
- D_IN[7] stuck at 1 with BUSY_TIMEOUT=3: 4 status reads, then timeout_err=1 and the write still completes. The flag stays set through the next write and clears only on nRST.
- nRST pulsed during the DATA PULSE phase: nWR=1, nCS=1, D_OE=0 immediately, nIC=0 on the next edge, and the request is not re-accepted until INIT completes.
